// File: rtl/xbox_host_regs_apb_if.sv
// APB3 slave bus bundle for the XBOX host register bank.
interface xbox_host_regs_apb_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/xbox_host_regs_apb.sv
// APB register bank driving the XBOX command/status interface of one accelerator,
// with accelerator read-back override and a sticky completion interrupt.
module xbox_host_regs_apb #(
  parameter int RD_WAIT = 1,
  parameter int IRQ_REG = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  xbox_host_regs_apb_if.slave   apb,
  output logic [31:0][31:0]     host_regs,
  output logic [31:0]           host_regs_valid_pulse,
  input  logic [31:0][31:0]     host_regs_data_out,
  input  logic [31:0]           host_regs_valid_out,
  output logic                  xlr_irq
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]  state;
  logic [2:0]  cnt;
  logic        err_q;
  logic [31:0] prdata_q;
  logic        irq_pending;
  logic        vld0_prev;

  logic [4:0]  idx;
  logic        addr_err;
  logic        setup;
  logic        complete;
  logic        is_irq;
  logic        wr_ok;
  logic        irq_set;
  logic        irq_clr;
  logic        capture;
  logic [31:0] rd_src;
  logic [31:0] strb_mask;

  assign idx      = apb.paddr[6:2];
  assign addr_err = (apb.paddr[11:7] != 5'd0) || (apb.paddr[1:0] != 2'd0);
  assign setup    = (state == ST_IDLE) && apb.psel && !apb.penable;
  assign complete = (state == ST_ACCESS) && (cnt == 3'd0) && apb.psel && apb.penable;
  assign is_irq   = (idx == 5'(IRQ_REG));
  assign wr_ok    = complete && apb.pwrite && !err_q;
  assign irq_set  = host_regs_valid_out[0] && !vld0_prev;
  assign irq_clr  = wr_ok && is_irq && apb.pwdata[0];
  // Read data is sampled one cycle before pready so prdata can be a clean register.
  assign capture  = (state == ST_ACCESS) && (cnt == 3'd1) && apb.psel && !apb.pwrite;

  assign strb_mask = {{8{apb.pstrb[3]}}, {8{apb.pstrb[2]}},
                      {8{apb.pstrb[1]}}, {8{apb.pstrb[0]}}};

  always_comb begin
    rd_src = host_regs[idx];
    if (is_irq)
      rd_src = {31'd0, irq_pending};
    else if (host_regs_valid_out[idx])
      rd_src = host_regs_data_out[idx];
  end

  // Transfer controller: setup loads the wait counter, access waits it out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            state <= ST_ACCESS;
            err_q <= addr_err;
            cnt   <= (apb.pwrite || addr_err) ? 3'd0 : 3'(RD_WAIT);
          end
        end
        default: begin
          if (!apb.psel) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
          end else if (complete) begin
            state <= ST_IDLE;
          end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prdata_q <= 32'd0;
    else
      prdata_q <= capture ? rd_src : 32'd0;
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = (state == ST_ACCESS) && (cnt == 3'd0);
  assign apb.pslverr = complete && err_q;

  // Register update and pulse land together in the cycle after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_regs             <= '0;
      host_regs_valid_pulse <= '0;
    end else begin
      host_regs_valid_pulse <= '0;
      if (wr_ok && !is_irq) begin
        host_regs[idx]             <= (host_regs[idx] & ~strb_mask) | (apb.pwdata & strb_mask);
        host_regs_valid_pulse[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0_prev   <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      vld0_prev <= host_regs_valid_out[0];
      if (irq_set)
        irq_pending <= 1'b1;
      else if (irq_clr)
        irq_pending <= 1'b0;
    end
  end

  assign xlr_irq = irq_pending;

endmodule

// File: tb/tb_xbox_host_regs_apb.sv
// Scoreboard bench for xbox_host_regs_apb: driver pushes expected responses and pulses,
// a negedge monitor pops and compares them against DUT activity.
module tb_xbox_host_regs_apb;
  localparam int RD_WAIT = 3;
  localparam int IRQ_REG = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbox_host_regs_apb_if apb ();
  logic [31:0][31:0] host_regs;
  logic [31:0]       pulse;
  logic [31:0][31:0] data_out;
  logic [31:0]       valid_out;
  logic              xlr_irq;

  xbox_host_regs_apb #(.RD_WAIT(RD_WAIT), .IRQ_REG(IRQ_REG)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .apb                   (apb),
    .host_regs             (host_regs),
    .host_regs_valid_pulse (pulse),
    .host_regs_data_out    (data_out),
    .host_regs_valid_out   (valid_out),
    .xlr_irq               (xlr_irq)
  );

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct { int idx; logic [31:0] val; } pulse_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_regs [32];
  bit          irq_model;
  resp_t       resp_q [$];
  pulse_t      pulse_q [$];
  resp_t       mon_r;
  pulse_t      mon_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_all(input string name);
    int bad = 0;
    for (int i = 0; i < 32; i++)
      if (host_regs[i] !== model_regs[i]) bad++;
    chk(name, bad, 0);
  endtask

  // Monitor: completions pop the response queue, pulses pop the pulse queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (apb.psel && apb.penable && apb.pready) begin
        if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          mon_r = resp_q.pop_front();
          chk("prdata", apb.prdata, mon_r.rdata);
          chk("pslverr", {31'd0, apb.pslverr}, {31'd0, mon_r.err});
        end
      end else begin
        chk("idle_prdata_pslverr", apb.prdata | {31'd0, apb.pslverr}, 32'd0);
      end
      if (pulse != 32'd0) begin
        if (pulse_q.size() == 0) chk("pulse_unexpected", pulse, 32'd0);
        else begin
          mon_p = pulse_q.pop_front();
          chk("pulse_vec", pulse, 32'h1 << mon_p.idx);
          chk("pulse_data", host_regs[mon_p.idx], mon_p.val);
        end
      end
    end
  end

  task automatic xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input bit rise_at_done);
    bit          err;
    int          idx;
    int          cyc;
    int          exp_lat;
    resp_t       r;
    pulse_t      p;
    logic [31:0] m;
    err = (addr[11:7] != 0) || (addr[1:0] != 0);
    idx = int'(addr[6:2]);
    r.err = err;
    r.rdata = 32'd0;
    if (wr) begin
      if (!err) begin
        if (idx == IRQ_REG) begin
          if (wd[0]) irq_model = 1'b0;
        end else begin
          m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
          model_regs[idx] = (model_regs[idx] & ~m) | (wd & m);
          p.idx = idx;
          p.val = model_regs[idx];
          pulse_q.push_back(p);
        end
      end
    end else if (!err) begin
      if (idx == IRQ_REG) r.rdata = {31'd0, irq_model};
      else r.rdata = valid_out[idx] ? data_out[idx] : model_regs[idx];
    end
    resp_q.push_back(r);
    exp_lat = (wr || err) ? 1 : 1 + RD_WAIT;

    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
    apb.paddr = addr; apb.pwdata = wd; apb.pstrb = st;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    cyc = 1;
    @(negedge clk);
    while (!apb.pready && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!apb.pready) chk("pready_timeout", 0, 1);
    else chk("latency", cyc, exp_lat);
    if (rise_at_done) begin
      valid_out[0] = 1'b1;
      irq_model = 1'b1;
    end
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [11:0] a;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0;
    data_out = '0; valid_out = '0;
    irq_model = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", apb.prdata, 0);
    chk("rst_pready", {31'd0, apb.pready}, 0);
    chk("rst_pslverr", {31'd0, apb.pslverr}, 0);
    chk("rst_irq", {31'd0, xlr_irq}, 0);
    chk("rst_pulse", pulse, 0);
    compare_all("rst_regs");
    rst_n = 1'b1;

    xfer(1, 12'h00C, 32'h0000_000A, 4'b1111, 0);
    chk("reg3", host_regs[3], 32'h0000_000A);
    xfer(1, 12'h020, 32'h1122_3344, 4'b1111, 0);
    xfer(1, 12'h020, 32'hAABB_CCDD, 4'b0101, 0);
    chk("merge_reg8", host_regs[8], 32'h11BB_33DD);
    xfer(1, 12'h010, 32'h1234_5678, 4'b0000, 0);
    xfer(1, 12'h004, 32'hCAFE_0001, 4'b1111, 0);
    xfer(0, 12'h004, 32'h0, 4'b0, 0);
    data_out[1] = 32'h1; valid_out[1] = 1'b1;
    xfer(0, 12'h004, 32'h0, 4'b0, 0);

    xfer(1, 12'h080, 32'hFFFF_FFFF, 4'b1111, 0);
    xfer(0, 12'h080, 32'h0, 4'b0, 0);
    xfer(1, 12'h006, 32'hFFFF_FFFF, 4'b1111, 0);
    xfer(0, 12'h006, 32'h0, 4'b0, 0);
    compare_all("err_no_change");

    @(posedge clk); #1;
    valid_out[0] = 1'b1; irq_model = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_set", {31'd0, xlr_irq}, {31'd0, irq_model});
    xfer(0, 12'h078, 32'h0, 4'b0, 0);
    xfer(1, 12'h078, 32'h0000_0001, 4'b1111, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("irq_clear_held", {31'd0, xlr_irq}, {31'd0, irq_model});
    chk("irqreg_unchanged", host_regs[IRQ_REG], model_regs[IRQ_REG]);
    valid_out[0] = 1'b0;
    @(posedge clk); #1;
    valid_out[0] = 1'b1; irq_model = 1'b1;
    @(posedge clk); #1;
    valid_out[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    xfer(1, 12'h078, 32'hFFFF_FFFF, 4'b1111, 1);
    #1;
    chk("irq_set_wins", {31'd0, xlr_irq}, {31'd0, irq_model});

    for (int n = 0; n < 60; n++) begin
      v = $urandom;
      valid_out = {v[31:1], valid_out[0]};
      for (int i = 0; i < 32; i++) data_out[i] = $urandom;
      a = {5'd0, 5'($urandom_range(0, 31)), 2'd0};
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) a[11:7] = 5'($urandom_range(1, 31));
        else a[1:0] = 2'($urandom_range(1, 3));
      end
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0);
    end
    compare_all("random_regs");
    chk("random_irq", {31'd0, xlr_irq}, {31'd0, irq_model});

    valid_out = '0;
    repeat (2) @(posedge clk);
    #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 12'h004;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    irq_model = 1'b0;
    chk("midrst_pready", {31'd0, apb.pready}, 0);
    chk("midrst_prdata", apb.prdata, 0);
    chk("midrst_irq", {31'd0, xlr_irq}, 0);
    chk("midrst_pulse", pulse, 0);
    compare_all("midrst_regs");
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_pready", {31'd0, apb.pready}, 0);
    xfer(1, 12'h00C, 32'h0000_5A5A, 4'b1111, 0);
    xfer(0, 12'h00C, 32'h0, 4'b0, 0);
    compare_all("post_rst_regs");

    repeat (4) @(posedge clk);
    #1;
    chk("resp_q_empty", resp_q.size(), 0);
    chk("pulse_q_empty", pulse_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xbox_host_regs_apb.md
# xbox_host_regs_apb

APB-slave register bank that generates the XBOX command/status register interface consumed by accelerators. It sits between the SoC APB fabric and one accelerator instance. It holds 32 host-written 32-bit registers and drives them with per-register write pulses. Host reads return accelerator-supplied status wherever the accelerator validates it. A sticky completion interrupt is raised from accelerator register 0.

## Interface
- RD_WAIT, 1: APB wait states inserted on reads; legal range 1..7.
- IRQ_REG, 30: register index whose host-visible read and write behaviour is replaced by the interrupt status/clear function.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  APB direction; 1 = write.
- paddr  in  12  APB byte address.
- pwdata  in  32  APB write data.
- pstrb  in  4  APB byte strobes.
- prdata  out  32  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- host_regs  out  [31:0][31:0]  register contents as last written by the host.
- host_regs_valid_pulse  out  32  one-cycle pulse per register on a host write.
- host_regs_data_out  in  [31:0][31:0]  accelerator read-back data.
- host_regs_valid_out  in  32  per-register accelerator override valid (level).
- xlr_irq  out  1  sticky completion interrupt.

## Operation
- Address decode:
  - idx = paddr[6:2].
  - A transfer is an error when paddr[11:7] != 0 or paddr[1:0] != 0.
- Controller states:
  - IDLE: default state. A setup cycle (psel=1, penable=0) moves to ACCESS and loads the wait counter. The counter loads 0 for writes and errors, RD_WAIT for reads.
  - ACCESS: the counter decrements each cycle while it is nonzero. pready = (counter == 0). When pready=1 and penable=1, the transfer completes and the state returns to IDLE.
  - A new transfer always needs a fresh setup cycle.
- Write completion (non-error, idx != IRQ_REG):
  - host_regs[idx] byte lanes are updated where pstrb=1; other lanes hold.
  - host_regs_valid_pulse[idx] is driven to 1 for exactly the next cycle.
  - pstrb=0000 still produces the pulse.
- Write to IRQ_REG:
  - pwdata[0]=1 clears irq_pending. Other bits are ignored.
  - host_regs[IRQ_REG] is not updated and no pulse is issued.
- Read data source:
  - A read of idx returns host_regs_data_out[idx] if host_regs_valid_out[idx]=1, else host_regs[idx].
  - IRQ_REG reads return {31'b0, irq_pending}.
- Interrupt:
  - irq_pending sets on a rising edge of host_regs_valid_out[0], detected with a registered previous value that resets to 0.
  - xlr_irq = irq_pending.
  - If a set and a clear land in the same cycle, the set wins.
- Error transfers:
  - pslverr=1 during the completing cycle, and prdata=0.
  - No register, pulse or irq side effects.
- prdata and pslverr are 0 in every cycle except the completing cycle.

## Timing
- Reset values:
  - prdata=0, pready=0, pslverr=0, xlr_irq=0.
  - All host_regs=0, all host_regs_valid_pulse=0.
  - State IDLE, counter 0, irq_pending=0, previous-valid register 0.
- Write latency:
  - Setup at cycle S; completes at S+1 (zero wait).
  - The new host_regs value and the pulse are both visible in cycle S+2, so an accelerator sees data and pulse in the same cycle.
- Read latency:
  - Setup at S; pready=1 in cycle S+1+RD_WAIT.
  - prdata is registered. It is captured from the sources in the cycle before pready rises.
- Back-to-back writes to the same register produce pulses in consecutive-transfer order, never merged. Minimum spacing is 2 cycles.
- Reset asserted mid-transfer:
  - Immediate return to IDLE with pready=0 and no pending write side effect.
  - A pulse in flight is cleared.
- psel dropping in ACCESS before completion: abort to IDLE with no side effects.
- host_regs_valid_out[0] held high does not retrigger. Only a 0->1 edge sets irq_pending.

## Test plan
- Write 0x0000_000A to 0x00C with pstrb=1111 -> host_regs[3]=10 and valid_pulse[3]=1 for one cycle at S+2; all other pulses 0.
- Write 0xAABB_CCDD to 0x020 with pstrb=0101 over an existing 0x1122_3344 -> host_regs[8]=0x11BB_33DD, pulse[8] asserted.
- Read 0x004 with valid_out[1]=0 -> returns host_regs[1]; set valid_out[1]=1, data_out[1]=0x1 -> read returns 0x1; pready rises RD_WAIT+1 cycles after setup.
- Raise valid_out[0] and hold it -> xlr_irq=1; read 0x078 -> 0x1; write 0x1 to 0x078 -> xlr_irq=0 and host_regs[30] unchanged. Repeat with a clear coincident with a new rising edge -> irq stays 1.
- Access 0x080 and 0x006 -> pslverr=1, prdata=0, no pulse, no register change.
- Assert rst_n=0 during the read wait state, then release -> all outputs at reset values; the next write completes normally.
